switch_egress_receiver: RTL

//  Sink for one switch output port (the switch-to-endpoint direction of a port). Accepts flits, frames them into

---
 rtl/switch_egress_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/switch_egress_receiver.sv
// Purpose: frames flits from one switch output port into packets and buffers them for a local consumer.
// Latency: a flit accepted at edge t is visible on rd_* after edge t; packet_sent follows an eop pop by one cycle.
// Backpressure: none toward the switch (credit-based); a flit arriving on a full FIFO is dropped and flagged.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it.
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module switch_egress_receiver #(
  parameter int FLIT_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEN_LSB     = 0,
  parameter int LEN_WIDTH   = 8,
  parameter int MAX_PKT_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_valid,
  output logic                  packet_sent,
  input  logic                  rd_en,
  output logic [FLIT_WIDTH-1:0] rd_flit,
  output logic                  rd_valid,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic [7:0]            pkt_count,
  output logic                  overflow_err,
  output logic                  len_err
);
  localparam int EW = FLIT_WIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_LEN);

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] rem, rem_nxt;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 sop, eop;
  logic                 pkt_done;
  logic                 len_bad;

  logic [EW-1:0]        head_dat;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 drop;

  assign hdr_len = in_flit[LEN_LSB +: LEN_WIDTH];

  // Framing: the header's length field counts the body flits that follow it.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    sop       = 1'b0;
    eop       = 1'b0;
    pkt_done  = 1'b0;
    len_bad   = 1'b0;
    case (state)
      HDR: begin
        sop = 1'b1;
        if (in_valid) begin
          len_bad = (hdr_len > MAX_LEN);
          if (hdr_len == '0) begin
            eop      = 1'b1;
            pkt_done = 1'b1;
          end else begin
            rem_nxt   = hdr_len;
            state_nxt = BODY;
          end
        end
      end
      BODY: begin
        if (in_valid) begin
          rem_nxt = rem - LEN_WIDTH'(1);
          if (rem == LEN_WIDTH'(1)) begin
            eop       = 1'b1;
            pkt_done  = 1'b1;
            state_nxt = HDR;
          end
        end
      end
      default: state_nxt = HDR;
    endcase
  end

  // Framing state advances on every valid flit, even a dropped one, so framing stays aligned with the switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  assign pop  = rd_en & ~fifo_empty;
  assign drop = in_valid & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_dat ({sop, eop, in_flit}),
    .pop      (rd_en),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Head entry is masked while empty so stale storage never leaks to the consumer.
  assign rd_valid = ~fifo_empty;
  assign rd_sop   = rd_valid & head_dat[EW-1];
  assign rd_eop   = rd_valid & head_dat[EW-2];
  assign rd_flit  = rd_valid ? head_dat[FLIT_WIDTH-1:0] : '0;

  // Packet counter, credit-return pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count    <= '0;
      packet_sent  <= 1'b0;
      overflow_err <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      if (pkt_done) pkt_count <= pkt_count + 8'd1;
      packet_sent <= pop & head_dat[EW-2];
      if (drop)    overflow_err <= 1'b1;
      if (len_bad) len_err      <= 1'b1;
    end
  end
endmodule
